// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: tracks in-flight producers through E/M/W,
// generates the D-stage stall and operand forwarding selects. Forwarding enabled by `HAZARD_FWD_EN.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  input  logic       d_krt,
  input  logic [1:0] d_tuse1,
  input  logic [1:0] d_tuse2,
  input  logic [1:0] d_dreg,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic [4:0] w_dst
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  localparam stage_t NO_STAGE = '0;

  stage_t e_q, m_q, w_q;
  stage_t e_d, m_d, w_d;

  logic [4:0] d_dst;
  logic       rs_rd, rt_rd;
  logic [1:0] rs_hit, rt_hit;
  logic       unused_bits;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Returns 1/2/3 for the youngest stage whose dst matches src, 0 if none; $0 never matches.
  function automatic logic [1:0] find_hit(input logic [4:0] src, input stage_t s1,
                                          input stage_t s2, input stage_t s3);
    if (src == 5'd0)          return 2'd0;
    else if (s1.dst == src)   return 2'd1;
    else if (s2.dst == src)   return 2'd2;
    else if (s3.dst == src)   return 2'd3;
    else                      return 2'd0;
  endfunction

  function automatic logic [1:0] hit_tnew(input logic [1:0] hit, input stage_t s1,
                                          input stage_t s2, input stage_t s3);
    case (hit)
      2'd1:    return s1.tnew;
      2'd2:    return s2.tnew;
      2'd3:    return s3.tnew;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    d_dst  = 5'd0;
    case (d_dreg)
      2'd0:    d_dst = d_rt;
      2'd1:    d_dst = d_rd;
      2'd2:    d_dst = 5'd31;
      default: d_dst = 5'd0;
    endcase
    rs_rd  = (d_tuse1 != 2'd3);
    rt_rd  = d_krt;
    rs_hit = rs_rd ? find_hit(d_rs, e_q, m_q, w_q) : 2'd0;
    rt_hit = rt_rd ? find_hit(d_rt, e_q, m_q, w_q) : 2'd0;
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] rs_tnew, rt_tnew, rs_e_hit, rt_e_hit;

  always_comb begin
    rs_tnew  = hit_tnew(rs_hit, e_q, m_q, w_q);
    rt_tnew  = hit_tnew(rt_hit, e_q, m_q, w_q);
    // E operands can only be supplied by older stages; NO_STAGE fills the E slot.
    rs_e_hit = find_hit(e_q.rs, NO_STAGE, m_q, w_q);
    rt_e_hit = find_hit(e_q.rt, NO_STAGE, m_q, w_q);

    stall    = ((rs_hit != 2'd0) && (rs_tnew > d_tuse1)) ||
               ((rt_hit != 2'd0) && (rt_tnew > d_tuse2));
    fwd_rs_d = ((rs_hit != 2'd0) && (rs_tnew == 2'd0)) ? rs_hit : 2'd0;
    fwd_rt_d = ((rt_hit != 2'd0) && (rt_tnew == 2'd0)) ? rt_hit : 2'd0;
    fwd_rs_e = ((rs_e_hit != 2'd0) && (hit_tnew(rs_e_hit, NO_STAGE, m_q, w_q) == 2'd0))
               ? rs_e_hit : 2'd0;
    fwd_rt_e = ((rt_e_hit != 2'd0) && (hit_tnew(rt_e_hit, NO_STAGE, m_q, w_q) == 2'd0))
               ? rt_e_hit : 2'd0;
    fwd_rt_m = (m_q.rt != 5'd0) && (m_q.rt == w_q.dst);
  end
`else
  // Without bypass paths any pending write in E or M must drain to W first.
  always_comb begin
    stall    = (rs_hit == 2'd1) || (rs_hit == 2'd2) ||
               (rt_hit == 2'd1) || (rt_hit == 2'd2);
    fwd_rs_d = 2'd0;
    fwd_rt_d = 2'd0;
    fwd_rs_e = 2'd0;
    fwd_rt_e = 2'd0;
    fwd_rt_m = 1'b0;
  end
`endif

  always_comb begin
    e_d = NO_STAGE;
    if (!stall) begin
      e_d.dst  = d_dst;
      e_d.tnew = sat_dec(d_tnew);
      e_d.rs   = rs_rd ? d_rs : 5'd0;
      e_d.rt   = rt_rd ? d_rt : 5'd0;
    end
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = sat_dec(m_q.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= NO_STAGE;
      m_q <= NO_STAGE;
      w_q <= NO_STAGE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign w_dst       = w_q.dst;
  assign unused_bits = ^{w_q.rs, w_q.rt, w_q.tnew, d_tuse2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random D traffic, checked against an
// age-based model of in-flight producers (remaining tnew = D-relative tnew minus stages travelled).
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       d_krt;
  logic [1:0] d_tuse1, d_tuse2, d_dreg, d_tnew;
  logic       stall, fwd_rt_m;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [4:0] w_dst;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_krt(d_krt),
    .d_tuse1(d_tuse1), .d_tuse2(d_tuse2), .d_dreg(d_dreg), .d_tnew(d_tnew),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .w_dst(w_dst)
  );

  always #5 clk = ~clk;

  // h[0] left D one cycle ago (E), h[1] two cycles ago (M), h[2] three (W).
  typedef struct { int dst; int tnew; int rs; int rt; } ent_t;
  ent_t h[3];
  int x_stall, x_frsd, x_frtd, x_frse, x_frte, x_frtm, x_wdst;
  int s_stall, s_frsd, s_frte, s_frse, s_frtm;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rem(input int a);
    int r;
    r = h[a].tnew - (a + 1);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int young(input int src, input int from);
    for (int a = from; a < 3; a++)
      if (src != 0 && h[a].dst == src) return a;
    return -1;
  endfunction

  task automatic clear_model();
    for (int a = 0; a < 3; a++) h[a] = '{0, 0, 0, 0};
  endtask

  task automatic src_rule(input int src, input bit rd, input int tuse, output int st, output int fw);
    int a;
    st = 0; fw = 0;
    a  = rd ? young(src, 0) : -1;
    if (a >= 0) begin
      if (FWD) begin
        if (rem(a) > tuse) st = 1;
        if (rem(a) == 0)   fw = a + 1;
      end else if (a <= 1) st = 1;
    end
  endtask

  task automatic predict();
    int st1, st2, a;
    src_rule(int'(d_rs), d_tuse1 != 2'd3, int'(d_tuse1), st1, x_frsd);
    src_rule(int'(d_rt), d_krt, int'(d_tuse2), st2, x_frtd);
    x_stall = st1 | st2;
    a = young(h[0].rs, 1);
    x_frse = (FWD && a >= 0 && rem(a) == 0) ? a + 1 : 0;
    a = young(h[0].rt, 1);
    x_frte = (FWD && a >= 0 && rem(a) == 0) ? a + 1 : 0;
    x_frtm = (FWD && h[1].rt != 0 && h[1].rt == h[2].dst) ? 1 : 0;
    x_wdst = h[2].dst;
  endtask

  task automatic advance();
    int dst;
    case (d_dreg)
      2'd0: dst = int'(d_rt);
      2'd1: dst = int'(d_rd);
      2'd2: dst = 31;
      default: dst = 0;
    endcase
    h[2] = h[1];
    h[1] = h[0];
    if (x_stall != 0) h[0] = '{0, 0, 0, 0};
    else h[0] = '{dst, int'(d_tnew), (d_tuse1 != 2'd3) ? int'(d_rs) : 0, d_krt ? int'(d_rt) : 0};
  endtask

  // Called shortly after a rising edge with D inputs already set; returns 1 after the next edge.
  task automatic step();
    #2;
    predict();
    s_stall = int'(stall); s_frsd = int'(fwd_rs_d); s_frse = int'(fwd_rs_e);
    s_frte = int'(fwd_rt_e); s_frtm = int'(fwd_rt_m);
    chk("stall", int'(stall), x_stall);
    chk("fwd_rs_d", int'(fwd_rs_d), x_frsd);
    chk("fwd_rt_d", int'(fwd_rt_d), x_frtd);
    chk("fwd_rs_e", int'(fwd_rs_e), x_frse);
    chk("fwd_rt_e", int'(fwd_rt_e), x_frte);
    chk("fwd_rt_m", int'(fwd_rt_m), x_frtm);
    chk("w_dst", int'(w_dst), x_wdst);
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic setd(input int rs, input int rt, input int rd, input bit krt,
                      input int tu1, input int tu2, input int dreg, input int tnew);
    d_rs = rs[4:0]; d_rt = rt[4:0]; d_rd = rd[4:0]; d_krt = krt;
    d_tuse1 = tu1[1:0]; d_tuse2 = tu2[1:0]; d_dreg = dreg[1:0]; d_tnew = tnew[1:0];
  endtask

  task automatic nop();                        setd(0, 0, 0, 0, 3, 0, 3, 0);  endtask
  task automatic addu(input int rd, rs, rt);   setd(rs, rt, rd, 1, 1, 1, 1, 2); endtask
  task automatic beq(input int rs, rt);        setd(rs, rt, 0, 1, 0, 0, 3, 0);  endtask
  task automatic lw(input int rt, base);       setd(base, rt, 0, 0, 1, 0, 0, 3); endtask
  task automatic sw(input int rt, base);       setd(base, rt, 0, 1, 1, 2, 3, 0); endtask
  task automatic ori(input int rt, rs);        setd(rs, rt, 0, 0, 1, 0, 0, 2);  endtask
  task automatic jal();                        setd(0, 0, 0, 0, 3, 0, 2, 1);  endtask
  task automatic jr(input int rs);             setd(rs, 0, 0, 0, 0, 0, 3, 0);  endtask

  // Hold the current D instruction until the model says it issues; counts DUT stall cycles.
  task automatic issue(output int nst);
    nst = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      nst += s_stall;
      if (x_stall == 0) return;
    end
    chk("issue_bound", nst, -1);
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    nop();
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Async reset mid-cycle with a producer (dst 5, tnew 1) sitting in E.
    addu(5, 1, 2);
    issue(n);
    beq(5, 0);
    #2;
    chk("pre_reset_stall", int'(stall), 1);
    reset = 1'b1;
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_w_dst", int'(w_dst), 0);
    clear_model();
    reset = 1'b0;
    #1;
    step();
    drain();

    addu(3, 1, 2); issue(n);
    beq(3, 0);     issue(n);
    chk("alu_beq_stalls", n, FWD ? 1 : 2);
    chk("alu_beq_fwd_rs_d", s_frsd, FWD ? 2 : 0);
    drain();

    lw(4, 1);        issue(n);
    addu(5, 4, 4);   issue(n);
    chk("lw_alu_stalls", n, FWD ? 1 : 2);
    nop(); step();
    chk("lw_alu_fwd_rs_e", s_frse, FWD ? 3 : 0);
    chk("lw_alu_fwd_rt_e", s_frte, FWD ? 3 : 0);
    drain();

    lw(6, 1);  issue(n);
    sw(6, 1);  issue(n);
    chk("lw_sw_stalls", n, FWD ? 0 : 2);
    nop(); step();
    chk("lw_sw_fwd_rt_e", s_frte, 0);
    step();
    chk("lw_sw_fwd_rt_m", s_frtm, FWD ? 1 : 0);
    drain();

    jal();    issue(n);
    jr(31);   issue(n);
    chk("jal_jr_stalls", n, FWD ? 0 : 2);
    chk("jal_jr_fwd_rs_d", s_frsd, FWD ? 1 : 0);
    drain();

    ori(7, 1);  issue(n);
    lw(7, 1);   issue(n);
    beq(7, 0);  issue(n);
    chk("ori_lw_beq_stalls", n, 2);
    chk("ori_lw_beq_fwd_rs_d", s_frsd, FWD ? 3 : 0);
    drain();

    // Random D traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 400; i++) begin
      setd($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
